equal_burst_checker: RTL and testbench
======================================

Name: equal_burst_checker

Overview:
- Downstream consumer of the 64-bit equality stage.
- Accepts a burst of operand pairs (A, B) over a valid/ready stream and compares each pair.
- Keeps a sticky mismatch flag, a mismatch count, and the index of the first mismatching word.
- Emits a one-cycle summary at burst end; used by sv2v regression benches to self-check streamed results.

Parameters:
- WIDTH, 64, operand width in bits.
- CNT_W, 16, width of the burst-length, index and mismatch-count fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a burst (sampled only in IDLE).
- burst_len  input  CNT_W  words in the burst; sampled on start; 0 means an empty burst.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  checker can accept a pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- done  output  1  one-cycle pulse when the burst summary is valid.
- pass  output  1  1 if no mismatch occurred in the burst; valid with done, held until next start.
- mismatch_cnt  output  CNT_W  number of mismatching pairs; saturates at all-ones.
- first_idx  output  CNT_W  index of the first mismatch (0-based); all-ones if none.
- busy  output  1  high in RUN or DRAIN.

Behaviour:
- Reset values: in_ready=0, done=0, pass=0, mismatch_cnt=0, first_idx=all-ones, busy=0.
- Reset asserted mid-burst aborts the burst: no done pulse, state returns to IDLE.
- FSM states:
  - IDLE: in_ready=0. start with burst_len!=0 goes to RUN, clears counters, sets first_idx=all-ones. start with burst_len==0 goes to DRAIN directly.
  - RUN: in_ready=1. A transfer occurs when in_valid & in_ready. Each transfer increments word index idx. On the transfer of word burst_len-1, go to DRAIN.
  - DRAIN: one cycle; flushes the compare pipeline stage, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Compare pipeline: one register stage.
  - Transfer cycle: register eq = (a == b) as a full-width compare, plus the current idx.
  - Following cycle: update statistics from the registered values.
  - Result latency: the last pair's transfer edge to the done-high edge is 2 cycles (DRAIN, then DONE).
- Statistics update, when the registered eq is 0:
  - mismatch_cnt increments, saturating at 2^CNT_W-1.
  - If first_idx is all-ones, load it with the registered idx. Later mismatches never overwrite it.
- pass = (mismatch_cnt == 0), registered on entry to DONE.
- in_ready is never high outside RUN.
- start is ignored outside IDLE.
- in_valid outside RUN is ignored; nothing is counted.
- Empty burst: done pulses 2 cycles after start, pass=1, mismatch_cnt=0, first_idx=all-ones.
- Back-to-back: start in the cycle after done (IDLE) is accepted.
- Outputs pass, mismatch_cnt and first_idx hold their values until the next accepted start.

Optional Feature:
- Macro: EQUAL_BURST_CHECKER_DIFF_MASK_EN.
- When defined, an extra output first_diff (WIDTH) is added.
  - It captures a ^ b of the first mismatching pair, in the same cycle first_idx is loaded.
  - Reset and start clear it to 0.
- When undefined, the port and register are absent and behaviour is otherwise identical.

Decomposition:
- Package equal_chk_pkg:
  - FSM state enum: IDLE, RUN, DRAIN, DONE.
  - Constant NO_IDX = all-ones of CNT_W.
  - Saturating-increment function.
- Sub-module equal_cmp_stage: registered comparator. Inputs a, b, idx, xfer. Outputs registered eq, idx and valid, plus the diff mask when the macro is defined.
- Top equal_burst_checker instantiates the comparator and holds the FSM and statistics.

Test Plan:
- burst_len=4, pairs (5,5) (10,10) (0,0) (all-ones, all-ones) -> done 2 cycles after the 4th transfer, pass=1, mismatch_cnt=0, first_idx=16'hFFFF.
- burst_len=5, pairs (5,1) (-5,10) (10,10) (all-ones,10) (10,10) -> pass=0, mismatch_cnt=3, first_idx=0. With the macro, first_diff=64'h4.
- burst_len=3 with in_valid toggling every other cycle -> only handshaked pairs are counted; done follows the 3rd transfer by exactly 2 cycles.
- start with burst_len=0 -> done 2 cycles later, pass=1, in_ready never asserted.
- rst pulsed after 2 of 4 words -> no done; all outputs at reset values; a new start then gives a correct fresh summary.
- start asserted during RUN, plus in_valid held high in IDLE -> both ignored; counts unchanged.

Source files
------------

// File: rtl/equal_chk_pkg.sv
// Shared types and helpers for the equal_burst_checker block.
package equal_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_CNT_W-1:0] NO_IDX = '1;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/equal_cmp_stage.sv
// Registered full-width comparator: captures (a == b) and the word index on each transfer.
// Optional diff mask output when EQUAL_BURST_CHECKER_DIFF_MASK_EN is defined.
module equal_cmp_stage
  import equal_chk_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [CNT_W-1:0] idx_i,
  output logic             vld_o,
  output logic             eq_o,
  output logic [CNT_W-1:0] idx_o
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
  ,
  output logic [WIDTH-1:0] diff_o
`endif
);

  logic             vld_q;
  logic             eq_q;
  logic [CNT_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      eq_q  <= 1'b1;
      idx_q <= '0;
    end else begin
      vld_q <= xfer_i;
      if (xfer_i) begin
        eq_q  <= (a_i == b_i);
        idx_q <= idx_i;
      end
    end
  end

`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
  logic [WIDTH-1:0] diff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
    end else if (xfer_i) begin
      diff_q <= a_i ^ b_i;
    end
  end

  assign diff_o = diff_q;
`endif

  assign vld_o = vld_q;
  assign eq_o  = eq_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/equal_burst_checker.sv
// Burst-level equality checker: streams operand pairs, keeps mismatch statistics, pulses done.
// Optional first_diff output enabled by defining EQUAL_BURST_CHECKER_DIFF_MASK_EN.
module equal_burst_checker
  import equal_chk_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic             busy,
  output logic [1:0]       dbg_state
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
  ,
  output logic [WIDTH-1:0] first_diff
`endif
);

  // Stream handshake: a pair moves on a rising edge where in_valid && in_ready;
  // in_ready is high only in RUN and does not depend on in_valid.

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             pass_q, pass_d;
  logic             xfer;

  logic             cmp_vld;
  logic             cmp_eq;
  logic [CNT_W-1:0] cmp_idx;

`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
  logic [WIDTH-1:0] cmp_diff;
  logic [WIDTH-1:0] diff_q, diff_d;
`endif

  equal_cmp_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk    (clk),
    .rst    (rst),
    .xfer_i (xfer),
    .a_i    (a),
    .b_i    (b),
    .idx_i  (idx_q),
    .vld_o  (cmp_vld),
    .eq_o   (cmp_eq),
    .idx_o  (cmp_idx)
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
    ,
    .diff_o (cmp_diff)
`endif
  );

  assign xfer = in_valid && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    pass_d  = pass_q;
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
    diff_d  = diff_q;
`endif

    // Statistics trail the transfer by one cycle; the DRAIN state covers the last word.
    if (cmp_vld && !cmp_eq) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(ALL_ONES)));
      if (first_q == ALL_ONES) begin
        first_d = cmp_idx;
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
        diff_d  = cmp_diff;
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = burst_len;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = ALL_ONES;
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
          diff_d  = '0;
`endif
          state_d = (burst_len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == len_q - CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        pass_d  = (cnt_d == '0);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= ALL_ONES;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
    end else begin
      diff_q <= diff_d;
    end
  end

  assign first_diff = diff_q;
`endif

  assign in_ready     = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign first_idx    = first_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_equal_burst_checker.sv
// Directed bench for equal_burst_checker; first_diff checks compile in with EQUAL_BURST_CHECKER_DIFF_MASK_EN.
module tb_equal_burst_checker;
  import equal_chk_pkg::*;

  localparam int WIDTH = 64;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_idx;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
  logic [WIDTH-1:0] first_diff;
`endif

  int checks = 0;
  int errors = 0;

  equal_burst_checker #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .burst_len    (burst_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .first_idx    (first_idx),
    .busy         (busy),
    .dbg_state    (dbg_state)
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
    ,
    .first_diff   (first_diff)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    chk("ready_in_run", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_burst(input logic [CNT_W-1:0] len);
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic chk_summary(input string tag, input logic p, input logic [CNT_W-1:0] cnt,
                             input logic [CNT_W-1:0] fi);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_pass"}, 64'(pass), 64'(p));
    chk({tag, "_cnt"}, 64'(mismatch_cnt), 64'(cnt));
    chk({tag, "_first"}, 64'(first_idx), 64'(fi));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    burst_len = '0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) tick();

    // Reset values.
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_cnt", 64'(mismatch_cnt), 64'd0);
    chk("rst_first", 64'(first_idx), 64'hFFFF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
    chk("rst_diff", first_diff, 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Burst of 4 matching pairs.
    begin_burst(16'd4);
    chk("t1_busy", 64'(busy), 64'd1);
    send(64'd5, 64'd5);
    send(64'd10, 64'd10);
    send(64'd0, 64'd0);
    send('1, '1);
    chk("t1_drain_done", 64'(done), 64'd0);
    chk("t1_drain_ready", 64'(in_ready), 64'd0);
    chk("t1_drain_busy", 64'(busy), 64'd1);
    tick();
    chk_summary("t1", 1'b1, 16'd0, 16'hFFFF);
    chk("t1_done_busy", 64'(busy), 64'd0);
    tick();
    chk("t1_done_one_cycle", 64'(done), 64'd0);

    // Back-to-back: start in the IDLE cycle right after done; three mismatches.
    begin_burst(16'd5);
    send(64'd5, 64'd1);
    send(64'hFFFF_FFFF_FFFF_FFFB, 64'd10);
    send(64'd10, 64'd10);
    send('1, 64'd10);
    send(64'd10, 64'd10);
    chk("t2_drain_done", 64'(done), 64'd0);
    tick();
    chk_summary("t2", 1'b0, 16'd3, 16'd0);
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
    chk("t2_diff", first_diff, 64'h4);
`endif
    tick();
    chk("t2_hold_cnt", 64'(mismatch_cnt), 64'd3);
    chk("t2_hold_pass", 64'(pass), 64'd0);

    // in_valid toggling: idle cycles carry unequal data that must not be counted.
    begin_burst(16'd3);
    in_valid = 1'b0; a = 64'd9; b = 64'd8; tick();
    send(64'd3, 64'd3);
    in_valid = 1'b0; a = 64'd9; b = 64'd8; tick();
    send(64'd1, 64'd2);
    in_valid = 1'b0; a = 64'd9; b = 64'd8; tick();
    send(64'd7, 64'd0);
    chk("t3_drain_done", 64'(done), 64'd0);
    tick();
    chk_summary("t3", 1'b0, 16'd2, 16'd1);
    tick();

    // Empty burst.
    begin_burst(16'd0);
    chk("t4_ready0", 64'(in_ready), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_done_early", 64'(done), 64'd0);
    tick();
    chk_summary("t4", 1'b1, 16'd0, 16'hFFFF);
    chk("t4_ready1", 64'(in_ready), 64'd0);
    tick();

    // Reset after 2 of 4 words aborts the burst.
    begin_burst(16'd4);
    send(64'd1, 64'd0);
    send(64'd2, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready", 64'(in_ready), 64'd0);
    chk("t5_pass", 64'(pass), 64'd0);
    chk("t5_cnt", 64'(mismatch_cnt), 64'd0);
    chk("t5_first", 64'(first_idx), 64'hFFFF);
    chk("t5_busy", 64'(busy), 64'd0);
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
    chk("t5_diff", first_diff, 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_done", 64'(done), 64'd0);
    end
    begin_burst(16'd2);
    send(64'd0, 64'd1);
    send(64'd2, 64'd2);
    tick();
    chk_summary("t5_fresh", 1'b0, 16'd1, 16'd0);
    tick();

    // start during RUN is ignored (length stays 2); in_valid in IDLE is ignored.
    begin_burst(16'd2);
    start     = 1'b1;
    burst_len = 16'd7;
    send(64'd1, 64'd0);
    start = 1'b0;
    send(64'd4, 64'd4);
    chk("t6_drain_done", 64'(done), 64'd0);
    tick();
    chk_summary("t6", 1'b0, 16'd1, 16'd0);
`ifdef EQUAL_BURST_CHECKER_DIFF_MASK_EN
    chk("t6_diff", first_diff, 64'd1);
`endif
    tick();
    in_valid = 1'b1;
    a        = 64'd3;
    b        = 64'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_idle_ready", 64'(in_ready), 64'd0);
      chk("t6_idle_busy", 64'(busy), 64'd0);
      chk("t6_idle_done", 64'(done), 64'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("t6_idle_cnt", 64'(mismatch_cnt), 64'd1);
    chk("t6_idle_first", 64'(first_idx), 64'd0);
    chk("t6_idle_pass", 64'(pass), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
